// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Ports: 0 = instruction fetch, 1 = load/store.
package mem_arb_pkg;

  localparam int   MEM_ARB_WORD_SIZE = 32;
  localparam logic PORT_IF           = 1'b0;
  localparam logic PORT_LS           = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT,
    RESP
  } arb_state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker; on a tie the port that did not
// win last time is granted.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = PORT_IF;
    case (req)
      2'b01:   grant_idx = PORT_IF;
      2'b10:   grant_idx = PORT_LS;
      2'b11:   grant_idx = ~last;
      default: grant_idx = PORT_IF;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port word memory between fetch and load/store ports,
// sequencing each grant as IDLE/SETUP/STROBE/WAIT/RESP. Optional read
// timeout in WAIT is enabled with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE      = MEM_ARB_WORD_SIZE,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [WORD_SIZE-1:0] p0_addr,
  input  logic [WORD_SIZE-1:0] p0_wdata,
  output logic                 p0_ack,
  output logic [WORD_SIZE-1:0] p0_rdata,
  output logic                 p0_err,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [WORD_SIZE-1:0] p1_addr,
  input  logic [WORD_SIZE-1:0] p1_wdata,
  output logic                 p1_ack,
  output logic [WORD_SIZE-1:0] p1_rdata,
  output logic                 p1_err,
  output logic                 mem_start,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_valid,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_err
);

  arb_state_e           state_q, state_d;
  logic                 last_q, last_d;
  logic                 gnt_q, gnt_d;
  logic                 err_q, err_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_SIZE-1:0] p0_rdata_q, p0_rdata_d;
  logic [WORD_SIZE-1:0] p1_rdata_q, p1_rdata_d;
  logic                 grant_valid, grant_idx;
  logic                 timeout;

  mem_arb_rr u_rr (
    .req         ({p1_req, p0_req}),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts read WAIT cycles without mem_valid; cleared on the way into WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == STROBE)
      cnt_d = '0;
    else if (state_q == WAIT && !mem_we_q && !mem_valid && !timeout)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout = !mem_we_q && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = SETUP;
      SETUP:   state_d = mem_err ? RESP : STROBE;
      STROBE:  state_d = WAIT;
      // Writes have no completion from the memory, so one WAIT cycle suffices.
      WAIT:    if (mem_we_q || mem_valid || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d      = last_q;
    gnt_d       = gnt_q;
    err_d       = err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    case (state_q)
      IDLE: if (grant_valid) begin
        gnt_d       = grant_idx;
        last_d      = grant_idx;
        err_d       = 1'b0;
        mem_we_d    = (grant_idx == PORT_LS) ? p1_we    : p0_we;
        mem_addr_d  = (grant_idx == PORT_LS) ? p1_addr  : p0_addr;
        mem_wdata_d = (grant_idx == PORT_LS) ? p1_wdata : p0_wdata;
      end
      SETUP: if (mem_err) err_d = 1'b1;
      WAIT: if (!mem_we_q) begin
        if (mem_valid) begin
          if (gnt_q == PORT_LS) p1_rdata_d = mem_rdata;
          else                  p0_rdata_d = mem_rdata;
        end else if (timeout) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= PORT_LS;
      gnt_q       <= PORT_IF;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
    end
  end

  // Strobe and acks are gated by reset so they drop in the reset cycle itself.
  always_comb begin
    mem_start = (state_q == STROBE) && !reset;
    p0_ack    = (state_q == RESP) && (gnt_q == PORT_IF) && !reset;
    p1_ack    = (state_q == RESP) && (gnt_q == PORT_LS) && !reset;
    p0_err    = p0_ack && err_q;
    p1_err    = p1_ack && err_q;
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural word memory plus an
// ack scoreboard checked by a negedge monitor.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         p0_req, p0_we, p1_req, p1_we;
  logic [W-1:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic         p0_ack, p0_err, p1_ack, p1_err;
  logic [W-1:0] p0_rdata, p1_rdata;
  logic         mem_start, mem_we, mem_valid, mem_err;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.WORD_SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory, MEMORY_SIZE = 1024 words, acts on the rising edge of mem_start.
  logic [W-1:0] mem [0:1023];
  logic [W-1:0] ref_mem [0:1023];
  logic         start_prev = 1'b0;
  logic         valid_q = 1'b0;
  logic [W-1:0] rdata_q = '0;
  int           rd_lat = 0;
  int           lat_cnt = 0;
  int           start_rises = 0;
  logic         stub = 1'b0;

  assign mem_err   = (mem_addr >= 32'd1024);
  assign mem_valid = valid_q & ~stub;
  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    start_prev <= mem_start;
    if (mem_start && !start_prev) begin
      start_rises <= start_rises + 1;
      if (mem_we) begin
        mem[mem_addr[9:0]] <= mem_wdata;
        valid_q <= 1'b0;
      end else begin
        rdata_q <= mem[mem_addr[9:0]];
        if (rd_lat == 0) valid_q <= 1'b1;
        else begin valid_q <= 1'b0; lat_cnt <= rd_lat; end
      end
    end else if (lat_cnt > 0) begin
      if (lat_cnt == 1) valid_q <= 1'b1;
      lat_cnt <= lat_cnt - 1;
    end
  end

  typedef struct {
    int       port;
    logic     err;
    logic [W-1:0] rdata;
    int       cyc;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] hold0 = '0;
  logic [W-1:0] hold1 = '0;

  // Ack monitor: every ack must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (p0_ack || p1_ack) begin
      exp_t e;
      int   port;
      logic err;
      logic [W-1:0] rd;
      port = p1_ack ? 1 : 0;
      err  = p1_ack ? p1_err : p0_err;
      rd   = p1_ack ? p1_rdata : p0_rdata;
      total++;
      if (p0_ack && p1_ack) begin
        bad++;
        $display("FAIL dual_ack cyc=%0d got both acks, required one", cyc);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack cyc=%0d port=%0d required no ack", cyc, port);
      end else begin
        e = sb.pop_front();
        if (port !== e.port || cyc !== e.cyc) begin
          bad++;
          $display("FAIL ack_timing got port=%0d cyc=%0d required port=%0d cyc=%0d",
                   port, cyc, e.port, e.cyc);
        end
        total++;
        if (err !== e.err) begin
          bad++;
          $display("FAIL ack_err port=%0d got=%0b required=%0b", port, err, e.err);
        end
        total++;
        if (rd !== e.rdata) begin
          bad++;
          $display("FAIL ack_rdata port=%0d got=%h required=%h", port, rd, e.rdata);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({p0_ack, p1_ack, p0_err, p1_err, mem_start, mem_we} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b required=000000",
               {p0_ack, p1_ack, p0_err, p1_err, mem_start, mem_we});
    end
    total++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_mem_bus got addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    end
    total++;
    if (p0_rdata !== '0 || p1_rdata !== '0) begin
      bad++;
      $display("FAIL reset_rdata got %h/%h required 0", p0_rdata, p1_rdata);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_round_robin();
    int k, n;
    @(posedge clk); #1;
    k = cyc;
    p0_req = 1; p0_we = 0; p0_addr = 10;
    p1_req = 1; p1_we = 0; p1_addr = 11;
    hold0 = ref_mem[10]; hold1 = ref_mem[11];
    sb.push_back('{0, 1'b0, hold0, k + 4});
    sb.push_back('{1, 1'b0, hold1, k + 9});
    sb.push_back('{0, 1'b0, hold0, k + 14});
    sb.push_back('{1, 1'b0, hold1, k + 19});
    n = 0;
    while (sb.size() != 0 && n < 60) begin @(posedge clk); n++; end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL rr_drain pending=%0d required=0", sb.size());
      sb.delete();
    end
    #1 p0_req = 0; p1_req = 0;
  endtask

  task automatic test_write_read();
    int k, n;
    // port 0 write then read back
    @(posedge clk); #1;
    k = cyc;
    p0_req = 1; p0_we = 1; p0_addr = 5; p0_wdata = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    sb.push_back('{0, 1'b0, hold0, k + 4});
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
    #1 p0_req = 0;
    k = cyc;
    p0_req = 1; p0_we = 0;
    hold0 = ref_mem[5];
    sb.push_back('{0, 1'b0, hold0, k + 4});
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
    #1 p0_req = 0;
    // port 1 write must leave p1_rdata alone
    k = cyc;
    p1_req = 1; p1_we = 1; p1_addr = 6; p1_wdata = 32'h0BADF00D;
    ref_mem[6] = 32'h0BADF00D;
    sb.push_back('{1, 1'b0, hold1, k + 4});
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL wr_rd_drain pending=%0d required=0", sb.size());
      sb.delete();
    end
    #1 p1_req = 0;
  endtask

  task automatic test_latency();
    int k, n;
    rd_lat = 3;
    @(posedge clk); #1;
    k = cyc;
    p1_req = 1; p1_we = 0; p1_addr = 6;
    hold1 = ref_mem[6];
    sb.push_back('{1, 1'b0, hold1, k + 7});
    n = 0;
    while (sb.size() != 0 && n < 30) begin @(posedge clk); n++; end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL latency_drain pending=%0d required=0", sb.size());
      sb.delete();
    end
    #1 p1_req = 0;
    rd_lat = 0;
  endtask

  task automatic test_invalid();
    int k, n, s0;
    @(posedge clk); #1;
    k = cyc;
    s0 = start_rises;
    p1_req = 1; p1_we = 0; p1_addr = 2000;
    sb.push_back('{1, 1'b1, hold1, k + 2});
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL invalid_drain pending=%0d required=0", sb.size());
      sb.delete();
    end
    #1 p1_req = 0;
    repeat (2) @(posedge clk);
    total++;
    if (start_rises !== s0) begin
      bad++;
      $display("FAIL invalid_no_strobe got rises=%0d required=%0d", start_rises, s0);
    end
  endtask

  task automatic test_reset_mid();
    int k, n, s0;
    @(posedge clk); #1;
    k = cyc;
    s0 = start_rises;
    p0_req = 1; p0_we = 0; p0_addr = 5;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;   // now in STROBE
    #1;
    total++;
    if (mem_start !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_start got=%b required=0", mem_start);
    end
    @(posedge clk); #1;
    reset = 1'b0; p0_req = 0;
    @(negedge clk);
    total++;
    if ({p0_ack, p1_ack, p0_err, p1_err, mem_start, mem_we} !== 6'b0 ||
        mem_addr !== '0 || mem_wdata !== '0 || p0_rdata !== '0 || p1_rdata !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs ctrl=%b addr=%h rd0=%h required all 0",
               {p0_ack, p1_ack, p0_err, p1_err, mem_start, mem_we}, mem_addr, p0_rdata);
    end
    hold0 = '0; hold1 = '0;
    repeat (4) @(posedge clk);
    total++;
    if (start_rises !== s0) begin
      bad++;
      $display("FAIL mid_reset_no_strobe got rises=%0d required=%0d", start_rises, s0);
    end
    #1;
    k = cyc;
    p0_req = 1; p0_we = 0; p0_addr = 5;
    hold0 = ref_mem[5];
    sb.push_back('{0, 1'b0, hold0, k + 4});
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL reissue_drain pending=%0d required=0", sb.size());
      sb.delete();
    end
    #1 p0_req = 0;
  endtask

  task automatic test_timeout();
    int k, n;
    stub = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    p0_req = 1; p0_we = 0; p0_addr = 9;
`ifdef MEM_ARB_TIMEOUT_EN
    // WAIT is entered at edge k+3; ack lands TO cycles later with rdata held
    sb.push_back('{0, 1'b1, hold0, k + 3 + TO});
    n = 0;
    while (sb.size() != 0 && n < TO + 20) begin @(posedge clk); n++; end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL timeout_drain pending=%0d required=0", sb.size());
      sb.delete();
    end
    #1 p0_req = 0;
`else
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (p0_ack) n++;
    end
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL no_timeout_ack got acks=%0d required=0", n);
    end
    @(posedge clk); #1 reset = 1'b1; p0_req = 0;
    @(posedge clk); #1 reset = 1'b0;
    hold0 = '0; hold1 = '0;
`endif
    stub = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA500_0000 ^ i;
      ref_mem[i] = 32'hA500_0000 ^ i;
    end
    test_reset();
    test_round_robin();
    test_write_read();
    test_latency();
    test_invalid();
    test_reset_mid();
    test_timeout();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d required finish before 5000 cycles", cyc);
    $fatal(1, "watchdog");
  end

endmodule
